// File: rtl/dsdc_control.sv
// ============================================================================
//  Module      : dsdc_control
//  Description : Return-path control FSM. It moves each accepted 64-bit word
//                through decryption, then decompression, then the output
//                handshake. At the end of a stream it flushes the
//                decompressor. It also times out stalled handshakes and
//                raises a sticky error with a 64-bit error code. This block
//                holds no data; the datapath sits beside it.
//  Options     : DSDC_AUTO_RECOVER_EN - when defined, a key_config rise then
//                fall while in ERROR returns the block to IDLE.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsdc_control #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_config,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             decry_done,
  input  logic             decomp_done,
  input  logic             decomp_empty,
  input  logic             out_rcvd,
  output logic             rdy,
  output logic             decry_start,
  output logic             decomp_start,
  output logic             flush_decomp,
  output logic             out_valid,
  output logic             stall,
  output logic             stream_done,
  output logic             error,
  output logic [63:0]      error_code,
  output logic [CNT_W-1:0] word_count
);

  // The timer only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits are enough.
  localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KEYCFG = 3'd1,
    S_DECRY  = 3'd2,
    S_DECOMP = 3'd3,
    S_EMIT   = 3'd4,
    S_FLUSH  = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [TMR_W-1:0] timer;
  logic             last_flag;

  logic             in_wait_nxt;
  logic             timeout_hit;
  logic             err_kc;
  logic             err_dd;
  logic             err_enter;
  logic [63:0]      code_nxt;
  logic             decry_start_nxt;
  logic             decomp_start_nxt;
  logic             flush_nxt;
  logic             done_nxt;
  logic             cnt_inc;
  logic             cnt_clr;
  logic             last_load;
  logic             recover_req;

  assign rdy   = (state == S_IDLE) && !key_config;
  assign stall = (state == S_KEYCFG) || (state == S_ERROR) ||
                 ((state == S_IDLE) && !in_valid) ||
                 ((state == S_EMIT) && !out_rcvd);

  assign timeout_hit = (TIMEOUT != 0) && (timer == TMR_LAST);
  assign in_wait_nxt = (state_nxt == S_DECRY) || (state_nxt == S_DECOMP) ||
                       (state_nxt == S_EMIT)  || (state_nxt == S_FLUSH);

  // Protocol violations. Once in ERROR, key_config is only a recovery gesture
  // and stray done strobes are ignored.
  assign err_kc = key_config && (state != S_IDLE) && (state != S_KEYCFG) &&
                  (state != S_ERROR);
  assign err_dd = (decry_done && (state != S_DECRY) && (state != S_ERROR)) ||
                  (decomp_done && (state != S_DECOMP) && (state != S_FLUSH) &&
                   (state != S_ERROR));

`ifdef DSDC_AUTO_RECOVER_EN
  logic kc_prev;
  logic kc_armed;

  // Arm on a key_config rise seen while in ERROR; the later fall releases it.
  always_ff @(posedge clk) begin
    if (rst) begin
      kc_prev  <= 1'b0;
      kc_armed <= 1'b0;
    end else begin
      kc_prev <= key_config;
      if (state != S_ERROR) begin
        kc_armed <= 1'b0;
      end else if (key_config && !kc_prev) begin
        kc_armed <= 1'b1;
      end
    end
  end

  assign recover_req = (state == S_ERROR) && kc_armed && !key_config;
`else
  assign recover_req = 1'b0;
`endif

  // Next-state and next-output decode; protocol errors override any normal move.
  always_comb begin
    state_nxt        = state;
    err_enter        = 1'b0;
    code_nxt         = 64'h0;
    decry_start_nxt  = 1'b0;
    decomp_start_nxt = 1'b0;
    flush_nxt        = 1'b0;
    done_nxt         = 1'b0;
    cnt_inc          = 1'b0;
    cnt_clr          = 1'b0;
    last_load        = 1'b0;

    case (state)
      S_IDLE: begin
        if (key_config) begin
          state_nxt = S_KEYCFG;
        end else if (in_valid) begin
          state_nxt       = S_DECRY;
          decry_start_nxt = 1'b1;
          last_load       = 1'b1;
        end
      end
      S_KEYCFG: begin
        if (!key_config) state_nxt = S_IDLE;
      end
      S_DECRY: begin
        if (decry_done) begin
          state_nxt        = S_DECOMP;
          decomp_start_nxt = 1'b1;
        end else if (timeout_hit) begin
          state_nxt = S_ERROR;
          err_enter = 1'b1;
          code_nxt  = 64'h2;
        end
      end
      S_DECOMP: begin
        if (decomp_done) begin
          state_nxt = S_EMIT;
        end else if (timeout_hit) begin
          state_nxt = S_ERROR;
          err_enter = 1'b1;
          code_nxt  = 64'h3;
        end
      end
      S_EMIT: begin
        if (out_rcvd) begin
          cnt_inc = 1'b1;
          // last_flag stays set for the whole flush, so it also marks
          // residual words coming back from FLUSH.
          if (last_flag) begin
            state_nxt = S_FLUSH;
            flush_nxt = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end else if (timeout_hit) begin
          state_nxt = S_ERROR;
          err_enter = 1'b1;
          code_nxt  = 64'h4;
        end
      end
      S_FLUSH: begin
        if (decomp_done) begin
          if (decomp_empty) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
            cnt_clr   = 1'b1;
          end else begin
            state_nxt = S_EMIT;
          end
        end else if (timeout_hit) begin
          state_nxt = S_ERROR;
          err_enter = 1'b1;
          code_nxt  = 64'h3;
        end
      end
      S_ERROR: begin
        if (recover_req) begin
          state_nxt = S_IDLE;
          cnt_clr   = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (err_kc || err_dd) begin
      state_nxt        = S_ERROR;
      err_enter        = 1'b1;
      code_nxt         = err_kc ? 64'h1 : 64'h5;
      decry_start_nxt  = 1'b0;
      decomp_start_nxt = 1'b0;
      flush_nxt        = 1'b0;
      done_nxt         = 1'b0;
      cnt_inc          = 1'b0;
      cnt_clr          = 1'b0;
      last_load        = 1'b0;
    end
  end

  // State, timer, pulse and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      timer        <= '0;
      last_flag    <= 1'b0;
      decry_start  <= 1'b0;
      decomp_start <= 1'b0;
      flush_decomp <= 1'b0;
      out_valid    <= 1'b0;
      stream_done  <= 1'b0;
      error        <= 1'b0;
      error_code   <= 64'h0;
      word_count   <= '0;
    end else begin
      state <= state_nxt;

      if ((state_nxt != state) || !in_wait_nxt) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end

      decry_start  <= decry_start_nxt;
      decomp_start <= decomp_start_nxt;
      flush_decomp <= flush_nxt;
      stream_done  <= done_nxt;
      out_valid    <= (state_nxt == S_EMIT);
      error        <= (state_nxt == S_ERROR);

      if (err_enter) error_code <= code_nxt;

      if (last_load) begin
        last_flag <= in_last;
      end else if (cnt_clr) begin
        last_flag <= 1'b0;
      end

      if (cnt_clr) begin
        word_count <= '0;
      end else if (cnt_inc && (word_count != {CNT_W{1'b1}})) begin
        word_count <= word_count + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
